// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave is the unit's view; master is the requester plus memory.
interface load_store_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic            req;
  logic            is_store;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] load_data;
  logic            fault;
  logic [XLEN-1:0] dm_addr;
  logic [XLEN-1:0] dm_wdata;
  logic            dm_memread;
  logic            dm_memwrite;
  logic [XLEN-1:0] dm_rdata;

  modport slave (
    input  req, is_store, funct3, addr, store_data, dm_rdata,
    output busy, done, load_data, fault, dm_addr, dm_wdata, dm_memread, dm_memwrite
  );

  modport master (
    output req, is_store, funct3, addr, store_data, dm_rdata,
    input  busy, done, load_data, fault, dm_addr, dm_wdata, dm_memread, dm_memwrite
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64 load/store unit: turns one sized access into aligned doubleword reads/writes,
// with read-modify-write for sub-doubleword stores and extension for loads.
module load_store_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus
);

  typedef enum logic [2:0] {StIdle, StRd, StSmp, StWr, StDone} state_e;

  state_e            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   store_data_q, store_data_d;
  logic [XLEN-1:0]   buf_q, buf_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              fault_q, fault_d;

  logic              illegal, misaligned, out_of_range;
  logic [5:0]        shamt;
  logic [XLEN-1:0]   lane, lane_mask, wmask, merged, extended;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
      buf_q        <= '0;
      load_data_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      buf_q        <= buf_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
    end
  end

  // Request checks look at the live request, since they decide the IDLE transition.
  always_comb begin
    illegal      = (bus.funct3 == 3'b111) || (bus.is_store && bus.funct3[2]);
    out_of_range = |bus.addr[XLEN-1:ADDR_BITS];
    unique case (bus.funct3[1:0])
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = |bus.addr[1:0];
      2'b11:   misaligned = |bus.addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    shamt = {addr_q[2:0], 3'b000};
    lane  = bus.dm_rdata >> shamt;
    unique case (funct3_q[1:0])
      2'b00:   lane_mask = 64'h0000_0000_0000_00ff;
      2'b01:   lane_mask = 64'h0000_0000_0000_ffff;
      2'b10:   lane_mask = 64'h0000_0000_ffff_ffff;
      default: lane_mask = '1;
    endcase
    wmask  = lane_mask << shamt;
    merged = (bus.dm_rdata & ~wmask) | ((store_data_q << shamt) & wmask);
    unique case (funct3_q)
      3'b000:  extended = {{56{lane[7]}}, lane[7:0]};
      3'b001:  extended = {{48{lane[15]}}, lane[15:0]};
      3'b010:  extended = {{32{lane[31]}}, lane[31:0]};
      3'b100:  extended = {56'd0, lane[7:0]};
      3'b101:  extended = {48'd0, lane[15:0]};
      3'b110:  extended = {32'd0, lane[31:0]};
      default: extended = lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    buf_d        = buf_q;
    load_data_d  = load_data_q;
    fault_d      = fault_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          is_store_d   = bus.is_store;
          funct3_d     = bus.funct3;
          addr_d       = bus.addr;
          store_data_d = bus.store_data;
          if (illegal || misaligned || out_of_range) begin
            fault_d = 1'b1;
            state_d = StDone;
          end else begin
            fault_d = 1'b0;
            // A full doubleword store needs no read; the buffer is the write data.
            if (bus.is_store && bus.funct3 == 3'b011) begin
              buf_d   = bus.store_data;
              state_d = StWr;
            end else begin
              state_d = StRd;
            end
          end
        end
      end
      StRd:   state_d = StSmp;
      StSmp: begin
        if (is_store_q) begin
          buf_d   = merged;
          state_d = StWr;
        end else begin
          buf_d       = bus.dm_rdata;
          load_data_d = extended;
          state_d     = StDone;
        end
      end
      StWr:   state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.fault       = (state_q == StDone) && fault_q;
  assign bus.dm_memread  = (state_q == StRd);
  assign bus.dm_memwrite = (state_q == StWr);
  assign bus.dm_addr     = {addr_q[XLEN-1:3], 3'b000};
  assign bus.dm_wdata    = buf_q;
  assign bus.load_data   = load_data_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the 64-byte doubleword data memory in the RV64 datapath.
- Turns one LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD request into aligned 64-bit MemRead/MemWrite accesses.
- Sub-doubleword stores use read-modify-write (RMW).
- Loads are sign- or zero-extended.
- Misaligned, out-of-range and illegal-funct3 requests are flagged, and no memory access is issued for them.

Parameters:
- XLEN, 64, datapath width.
- ADDR_BITS, 6, byte-address bits backed by memory (64 bytes).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V size/sign code.
- addr  input  64  byte address.
- store_data  input  64  store operand; low bytes are used.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle completion pulse.
- load_data  output  64  extended load result; valid while done=1, held until the next done.
- fault  output  1  high with done when the request was rejected.
- dm_addr  output  64  aligned doubleword address to memory ({addr[63:3],3'b000}).
- dm_wdata  output  64  merged doubleword to memory.
- dm_memread  output  1  memory read enable.
- dm_memwrite  output  1  memory write enable.
- dm_rdata  input  64  memory read data.

Behaviour:
- Reset (reset=0 at a rising edge):
  - state goes to IDLE.
  - busy, done, fault, dm_memread and dm_memwrite are 0.
  - load_data, dm_addr and dm_wdata are 0.
  - Captured request registers are cleared.
- All dm_* strobes decode from the registered state, so there are no combinational paths from req to memory.
- Reset mid-operation:
  - It aborts the operation at that edge and no done is issued.
  - A WR cycle already in progress still presents dm_memwrite for that cycle.
  - Memory may therefore hold the merged value.
- IDLE:
  - If req=1, capture is_store, funct3, addr and store_data.
  - Set fault=1 and go to DONE when any of the following holds:
    - funct3=111, or is_store=1 with funct3[2]=1 (illegal);
    - misaligned: half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0;
    - out of range: addr[63:ADDR_BITS]≠0.
  - Otherwise:
    - SD goes to WR.
    - Any load, or SB/SH/SW, goes to RD.
  - req while busy=1 is ignored; the requester must wait for busy=0.
- RD: dm_memread=1, dm_addr aligned; next state is SMP.
- SMP: latch dm_rdata into the line buffer.
  - Load: extract the lane at addr[2:0] (bytes little-endian, byte k = bits 8k+7:8k).
    - funct3 000/001/010 sign-extend; 100/101/110 zero-extend; 011 is the full 64 bits.
    - Register the result into load_data and go to DONE.
  - Store: merge store_data[7:0] / [15:0] / [31:0] into the buffer lane at addr[2:0], leave the other bytes unchanged, and go to WR.
- WR:
  - dm_memwrite=1 for exactly one cycle; dm_memread=0 in this cycle.
  - dm_wdata is the merged buffer, or store_data for SD.
  - Next state is DONE.
- DONE:
  - done=1 for one cycle; fault is valid in this cycle.
  - Next state is IDLE; a new req is accepted on the following edge.
- Latency, counted from the req-accept edge to the done cycle:
  - load 3 cycles;
  - SD 2 cycles;
  - SB/SH/SW 4 cycles;
  - fault 1 cycle.
- dm_memread and dm_memwrite are never high together, and are never high in IDLE or DONE.
- load_data is unchanged by stores and faults.

Test Plan:
- SD addr=0x10, data=0x1122334455667788:
  - dm_memwrite pulses once with dm_addr=0x10.
  - done 2 cycles after accept, fault=0.
  - Then LD 0x10 returns 0x1122334455667788 with done at +3.
- SB addr=0x13, data=0xAB over memory 0x1122334455667788 at 0x10:
  - RD, then WR with dm_wdata=0x11223344AB667788.
  - done at +4.
- LB 0x13 after the previous step returns 0xFFFFFFFFFFFFFFAB; LBU 0x13 returns 0x00000000000000AB; LHU 0x12 returns 0x000000000000AB66.
- LW addr=0x12 (misaligned), LH addr=0x40 (out of range), SD funct3=100 (illegal):
  - each gives fault=1 with done one cycle after accept;
  - dm_memread and dm_memwrite stay 0 throughout;
  - load_data is unchanged.
- req pulsed again while busy=1 during an SW:
  - it is ignored, and only one done is produced.
- reset=0 asserted in the SMP cycle of an SH:
  - state returns to IDLE and dm_memwrite is never asserted;
  - done stays 0 and memory is unchanged.
